// File: rtl/vmask_pkg.sv
// Shared opcodes and sizing helpers for the vector mask pipeline.
package vmask_pkg;

  localparam logic [3:0] VM_AND   = 4'b0000;
  localparam logic [3:0] VM_ANDNN = 4'b0001;
  localparam logic [3:0] VM_NAND  = 4'b0010;
  localparam logic [3:0] VM_XOR   = 4'b0011;
  localparam logic [3:0] VM_OR    = 4'b0100;
  localparam logic [3:0] VM_ORNN  = 4'b0101;
  localparam logic [3:0] VM_NOR   = 4'b0110;
  localparam logic [3:0] VM_XNOR  = 4'b0111;
  localparam logic [3:0] VM_CPOP  = 4'b1000;
  localparam logic [3:0] VM_FIRST = 4'b1001;
  localparam logic [3:0] VM_SBF   = 4'b1010;
  localparam logic [3:0] VM_SIF   = 4'b1011;
  localparam logic [3:0] VM_SOF   = 4'b1100;

  localparam int VM_LAT_MIN = 2;

  function automatic int cpop_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/vmask_first_finder.sv
// Combinational first-set-bit finder producing the set-before/including/only-first masks.
module vmask_first_finder #(
  parameter  int W  = 64,
  localparam int PW = $clog2(W)
) (
  input  logic [W-1:0]  x_i,
  output logic          any_o,
  output logic [PW-1:0] p_o,
  output logic [W-1:0]  sbf_o,
  output logic [W-1:0]  sif_o,
  output logic [W-1:0]  sof_o
);

  // x & -x isolates the lowest set bit; x ^ (x-1) is all-ones when x == 0
  assign any_o = |x_i;
  assign sof_o = x_i & (~x_i + W'(1));
  assign sif_o = x_i ^ (x_i - W'(1));
  assign sbf_o = sif_o & ~sof_o;

  always_comb begin
    p_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (x_i[i]) p_o = PW'(i);
    end
  end

endmodule

// File: rtl/vmask_pipe.sv
// Pipelined vector mask unit: logical mask ops plus cross-beat vcpop/vfirst/vmsbf/vmsif/vmsof.
module vmask_pipe
  import vmask_pkg::*;
#(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH  = 32,
  parameter int OPSEL_WIDTH     = 4,
  parameter int XLEN            = 32,
  parameter int LATENCY         = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
  input  logic [REQ_DATA_WIDTH-1:0]  in_m0,
  input  logic [REQ_DATA_WIDTH-1:0]  in_m1,
  input  logic                       in_valid,
  input  logic [OPSEL_WIDTH-1:0]     in_opSel,
  input  logic                       in_start,
  input  logic                       in_end,
  output logic [REQ_ADDR_WIDTH-1:0]  out_addr,
  output logic [RESP_DATA_WIDTH-1:0] out_vec,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_scalar,
  output logic                       out_scalar_valid
);

  localparam int W  = REQ_DATA_WIDTH;
  localparam int PW = $clog2(W);
  localparam int IW = XLEN - PW;
  localparam int CW = cpop_width(W);
  localparam int DW = 2 + REQ_ADDR_WIDTH + RESP_DATA_WIDTH + XLEN;

  if (LATENCY < VM_LAT_MIN) begin : g_bad_latency
    $error("vmask_pipe: LATENCY below minimum");
  end
  if (RESP_DATA_WIDTH != REQ_DATA_WIDTH) begin : g_bad_width
    $error("vmask_pipe: RESP_DATA_WIDTH must equal REQ_DATA_WIDTH");
  end

  logic                      s0_valid_q, s0_start_q, s0_end_q;
  logic [OPSEL_WIDTH-1:0]    s0_op_q;
  logic [REQ_ADDR_WIDTH-1:0] s0_addr_q;
  logic [W-1:0]              s0_m0_q, s0_m1_q;

  // Invalid beats are zeroed here so every downstream field reads 0 when not valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_start_q <= 1'b0;
      s0_end_q   <= 1'b0;
      s0_op_q    <= '0;
      s0_addr_q  <= '0;
      s0_m0_q    <= '0;
      s0_m1_q    <= '0;
    end else begin
      s0_valid_q <= in_valid;
      s0_start_q <= in_valid & in_start;
      s0_end_q   <= in_valid & in_end;
      s0_op_q    <= in_valid ? in_opSel : '0;
      s0_addr_q  <= in_valid ? in_addr  : '0;
      s0_m0_q    <= in_valid ? in_m0    : '0;
      s0_m1_q    <= in_valid ? in_m1    : '0;
    end
  end

  logic          found_q, found_d, found_c;
  logic [XLEN-1:0] acc_q, acc_d, acc_c;
  logic [IW-1:0] idx_q, idx_d, idx_c;
  logic [W-1:0]  x, sbf, sif, sof, vec_d;
  logic [PW-1:0] p;
  logic          any;
  logic [CW-1:0] pop;
  logic [XLEN-1:0] sc_d;
  logic          scv_d;
  logic [DW-1:0] s1_q, s1_d;

  assign x = s0_m0_q & s0_m1_q;

  vmask_first_finder #(.W(W)) u_ff (
    .x_i   (x),
    .any_o (any),
    .p_o   (p),
    .sbf_o (sbf),
    .sif_o (sif),
    .sof_o (sof)
  );

  always_comb begin
    pop = '0;
    for (int i = 0; i < W; i++) pop = pop + CW'(x[i]);
  end

  // acc doubles as the latched vfirst position; a vector only ever uses one of the two meanings
  always_comb begin
    found_c = s0_start_q ? 1'b0 : found_q;
    acc_c   = s0_start_q ? '0   : acc_q;
    idx_c   = s0_start_q ? '0   : idx_q;
    found_d = found_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    vec_d   = '0;
    sc_d    = '0;
    scv_d   = 1'b0;
    if (s0_op_q inside {[VM_CPOP:VM_SOF]}) begin
      found_d = found_c;
      acc_d   = acc_c;
      idx_d   = idx_c + IW'(1);
    end
    case (s0_op_q)
      VM_AND:   vec_d = s0_m0_q & s0_m1_q;
      VM_ANDNN: vec_d = ~s0_m0_q & ~s0_m1_q;
      VM_NAND:  vec_d = ~(s0_m0_q & s0_m1_q);
      VM_XOR:   vec_d = s0_m0_q ^ s0_m1_q;
      VM_OR:    vec_d = s0_m0_q | s0_m1_q;
      VM_ORNN:  vec_d = ~s0_m0_q | ~s0_m1_q;
      VM_NOR:   vec_d = ~(s0_m0_q | s0_m1_q);
      VM_XNOR:  vec_d = ~(s0_m0_q ^ s0_m1_q);
      VM_CPOP:  acc_d = acc_c + XLEN'(pop);
      VM_FIRST: begin
        if (!found_c && any) begin
          acc_d   = {idx_c, p};
          found_d = 1'b1;
        end
      end
      VM_SBF: begin
        vec_d   = found_c ? '0 : sbf;
        found_d = found_c | any;
      end
      VM_SIF: begin
        vec_d   = found_c ? '0 : sif;
        found_d = found_c | any;
      end
      VM_SOF: begin
        vec_d   = found_c ? '0 : sof;
        found_d = found_c | any;
      end
      default: vec_d = '0;
    endcase
    if (s0_end_q && s0_op_q == VM_CPOP) begin
      scv_d = 1'b1;
      sc_d  = acc_d;
    end else if (s0_end_q && s0_op_q == VM_FIRST) begin
      scv_d = 1'b1;
      sc_d  = found_d ? acc_d : '1;
    end
  end

  assign s1_d = {s0_valid_q, scv_d, s0_addr_q, RESP_DATA_WIDTH'(vec_d), sc_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      found_q <= 1'b0;
      acc_q   <= '0;
      idx_q   <= '0;
      s1_q    <= '0;
    end else begin
      found_q <= found_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      s1_q    <= s1_d;
    end
  end

  genvar g;
  for (g = 0; g < LATENCY - 2; g++) begin : g_dly
    logic [DW-1:0] stage_q, stage_d;
    if (g == 0) begin : g_head
      assign stage_d = s1_q;
    end else begin : g_tail
      assign stage_d = g_dly[g-1].stage_q;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) stage_q <= '0;
      else     stage_q <= stage_d;
    end
  end

  logic [DW-1:0] pipe_out;
  if (LATENCY <= 2) begin : g_out_s1
    assign pipe_out = s1_q;
  end else begin : g_out_dly
    assign pipe_out = g_dly[LATENCY-3].stage_q;
  end

  assign {out_valid, out_scalar_valid, out_addr, out_vec, out_scalar} = pipe_out;

endmodule

// File: tb/tb_vmask_pipe.sv
// Scoreboard bench for vmask_pipe: element-level reference model, directed plus random vectors.
module tb_vmask_pipe;
  localparam int L = 6;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_addr = '0;
  logic [63:0] in_m0 = '0, in_m1 = '0;
  logic        in_valid = 1'b0, in_start = 1'b0, in_end = 1'b0;
  logic [3:0]  in_opSel = '0;
  logic [31:0] out_addr, out_scalar;
  logic [63:0] out_vec;
  logic        out_valid, out_scalar_valid;

  vmask_pipe #(.REQ_DATA_WIDTH(64), .RESP_DATA_WIDTH(64), .REQ_ADDR_WIDTH(32),
               .OPSEL_WIDTH(4), .XLEN(32), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .in_addr(in_addr), .in_m0(in_m0), .in_m1(in_m1),
    .in_valid(in_valid), .in_opSel(in_opSel), .in_start(in_start), .in_end(in_end),
    .out_addr(out_addr), .out_vec(out_vec), .out_valid(out_valid),
    .out_scalar(out_scalar), .out_scalar_valid(out_scalar_valid));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] vec;
    logic        sv;
    logic [31:0] sc;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_mon;

  // Reference state in element terms: global index of first set element (-1 none), running count, beat number
  longint first_g = -1;
  longint acc_m = 0;
  int     idx_m = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out actual=valid required=none time=%0t", $time);
        end else begin
          e_mon = exp_q.pop_front();
          check("addr", 64'(out_addr), 64'(e_mon.addr));
          check("vec", out_vec, e_mon.vec);
          check("scalar_valid", 64'(out_scalar_valid), 64'(e_mon.sv));
          check("scalar", 64'(out_scalar), 64'(e_mon.sc));
          check("latency", 64'(cyc - e_mon.cyc), 64'(L));
        end
      end else begin
        check("idle_zero", out_vec | 64'({out_addr, out_scalar}) | 64'(out_scalar_valid), 64'd0);
      end
    end
  end

  task automatic model_reset();
    first_g = -1;
    acc_m   = 0;
    idx_m   = 0;
  endtask

  task automatic model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic e,
                       output logic [63:0] v, output logic sv, output logic [31:0] sc);
    logic [63:0] x;
    longint eidx;
    v = '0; sv = 1'b0; sc = '0; x = a & b;
    case (op)
      4'd0: v = a & b;
      4'd1: v = ~a & ~b;
      4'd2: v = ~(a & b);
      4'd3: v = a ^ b;
      4'd4: v = a | b;
      4'd5: v = ~a | ~b;
      4'd6: v = ~(a | b);
      4'd7: v = ~(a ^ b);
      4'd8, 4'd9, 4'd10, 4'd11, 4'd12: begin
        if (s) model_reset();
        acc_m += $countones(x);
        if (first_g < 0) begin
          for (int i = 0; i < 64; i++) begin
            if (x[i]) begin
              first_g = longint'(idx_m) * 64 + i;
              break;
            end
          end
        end
        for (int i = 0; i < 64; i++) begin
          eidx = longint'(idx_m) * 64 + i;
          case (op)
            4'd10:   v[i] = (first_g < 0) || (first_g > eidx);
            4'd11:   v[i] = (first_g < 0) || (first_g >= eidx);
            4'd12:   v[i] = (first_g == eidx);
            default: v[i] = 1'b0;
          endcase
        end
        if (e && op == 4'd8) begin
          sv = 1'b1;
          sc = 32'(acc_m);
        end
        if (e && op == 4'd9) begin
          sv = 1'b1;
          sc = (first_g < 0) ? 32'hFFFF_FFFF : 32'(first_g);
        end
        idx_m++;
      end
      default: v = '0;
    endcase
  endtask

  task automatic beat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic s, input logic e, input logic [31:0] ad,
                      input bit use_x = 0, input logic [63:0] xv = '0, input logic [31:0] xs = '0);
    exp_t n;
    logic [63:0] v;
    logic sv;
    logic [31:0] sc;
    in_valid = 1'b1; in_opSel = op; in_m0 = a; in_m1 = b;
    in_start = s; in_end = e; in_addr = ad;
    model(op, a, b, s, e, v, sv, sc);
    n.addr = ad;
    n.vec  = use_x ? xv : v;
    n.sv   = sv;
    n.sc   = use_x ? xs : sc;
    n.cyc  = cyc;
    exp_q.push_back(n);
    @(posedge clk); #1;
  endtask

  task automatic bubble();
    in_valid = 1'b0;
    in_opSel = 4'($urandom);
    in_m0 = {$urandom, $urandom};
    in_m1 = {$urandom, $urandom};
    in_start = 1'($urandom);
    in_end = 1'($urandom);
    in_addr = $urandom;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_valid", 64'({out_valid, out_scalar_valid}), 64'd0);
    check("rst_data", out_vec | 64'({out_addr, out_scalar}), 64'd0);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [63:0] rnd_mask();
    logic [63:0] m;
    case ($urandom_range(0, 3))
      0:       m = '0;
      1:       m = 64'd1 << $urandom_range(0, 63);
      2:       m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      default: m = {$urandom, $urandom};
    endcase
    return m;
  endfunction

  logic [63:0] xv0, xv1;
  logic [3:0]  rop;
  int          len;
  bit          abort;

  initial begin
    @(posedge clk); #1;
    check("reset_state", out_vec | 64'({out_addr, out_scalar}) | 64'({out_valid, out_scalar_valid}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    beat(4'd0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 0, 0, 32'h40, 1, 64'hF000_F000_F000_F000, 0);

    beat(4'd8, ONES, ONES, 1, 0, 32'h1, 1, 0, 0);
    beat(4'd8, 64'h1, ONES, 0, 0, 32'h2, 1, 0, 0);
    beat(4'd8, 64'h0, ONES, 0, 1, 32'h3, 1, 0, 65);

    beat(4'd9, 64'h0, ONES, 1, 0, 32'h10, 1, 0, 0);
    beat(4'd9, 64'h100, ONES, 0, 1, 32'h11, 1, 0, 72);
    beat(4'd9, 64'h0, ONES, 1, 0, 32'h12, 1, 0, 0);
    beat(4'd9, 64'h0, ONES, 0, 1, 32'h13, 1, 0, 32'hFFFF_FFFF);

    for (int bub = 0; bub < 2; bub++) begin
      for (int op = 10; op <= 12; op++) begin
        xv0 = (op == 12) ? 64'h0 : ONES;
        xv1 = (op == 10) ? 64'hF : (op == 11) ? 64'h1F : 64'h10;
        beat(4'(op), 64'h0, ONES, 1, 0, 32'h20, 1, xv0, 0);
        if (bub != 0) bubble();
        beat(4'(op), 64'h10, ONES, 0, 1, 32'h21, 1, xv1, 0);
      end
    end

    beat(4'd8, ONES, ONES, 1, 0, 32'h30, 1, 0, 0);
    beat(4'd8, 64'h7, ONES, 0, 1, 32'h31, 1, 0, 67);
    beat(4'd8, 64'hF, ONES, 1, 0, 32'h32, 1, 0, 0);
    beat(4'd8, 64'h1, ONES, 0, 1, 32'h33, 1, 0, 5);
    beat(4'd8, 64'h3, ONES, 1, 1, 32'h34, 1, 0, 2);
    drain();

    // Reset lands while earlier beats are on the output and a vcpop vector is mid-flight
    for (int k = 0; k < 6; k++) beat(4'd3, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, $urandom);
    beat(4'd8, ONES, ONES, 1, 0, 32'h50);
    in_valid = 1'b1; in_opSel = 4'd8; in_m0 = ONES; in_m1 = ONES;
    in_start = 1'b0; in_end = 1'b0; in_addr = 32'h51;
    #2;
    do_reset();
    beat(4'd8, ONES, ONES, 1, 0, 32'h60, 1, 0, 0);
    beat(4'd8, ONES, ONES, 0, 1, 32'h61, 1, 0, 128);
    drain();

    do_reset();
    beat(4'd8, 64'h5, ONES, 0, 1, 32'h70, 1, 0, 2);
    drain();

    for (int vn = 0; vn < 200; vn++) begin
      rop = 4'($urandom_range(0, 15));
      if (rop < 4'd8 || rop > 4'd12) begin
        beat(rop, rnd_mask(), {$urandom, $urandom}, 1'($urandom), 1'($urandom), $urandom);
      end else begin
        len = $urandom_range(1, 4);
        abort = ($urandom_range(0, 5) == 0);
        for (int k = 0; k < len; k++) begin
          if ($urandom_range(0, 3) == 0) bubble();
          beat(rop, rnd_mask(), ($urandom_range(0, 1) == 0) ? ONES : rnd_mask(),
               k == 0, (k == len - 1) && !abort, $urandom);
        end
      end
    end
    drain();
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vmask_pipe.md
# vmask_pipe

Pipelined vector mask unit for the vALU: parametrised successor to the fixed-latency mask-logical block. It keeps the eight mask-logical operations and adds cross-beat mask operations: population count, find-first, and set-before/including/only-first. These operations need state carried across the beats of one vector. It sits beside the other vALU lanes, takes one mask beat per cycle with no backpressure, and returns results in order after a fixed, parametrised latency.

## Interface
- REQ_DATA_WIDTH, 64: mask beat width in bits; power of two.
- RESP_DATA_WIDTH, 64: output beat width; must equal REQ_DATA_WIDTH.
- REQ_ADDR_WIDTH, 32: destination address width, passed through.
- OPSEL_WIDTH, 4: opcode width.
- XLEN, 32: scalar result width.
- LATENCY, 6: in_valid to out_valid cycles; minimum 2.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_addr  in  REQ_ADDR_WIDTH  destination address of the beat.
- in_m0  in  REQ_DATA_WIDTH  source mask (vs2).
- in_m1  in  REQ_DATA_WIDTH  second operand (vs1), or the v0 mask for cross-beat ops; driven all-ones when unmasked.
- in_valid  in  1  beat valid.
- in_opSel  in  OPSEL_WIDTH  opcode.
- in_start  in  1  first beat of a vector; qualified by in_valid.
- in_end  in  1  last beat of a vector; qualified by in_valid.
- out_addr  out  REQ_ADDR_WIDTH  delayed in_addr.
- out_vec  out  RESP_DATA_WIDTH  result mask beat.
- out_valid  out  1  result beat valid.
- out_scalar  out  XLEN  vcpop/vfirst result.
- out_scalar_valid  out  1  out_scalar valid; only asserted with out_valid on an in_end beat of opcode 1000/1001.

## Operation
- Opcodes, with a = in_m0 and b = in_m1:
  - 0000 a&b, 0001 ~a&~b, 0010 ~(a&b), 0011 a^b.
  - 0100 a|b, 0101 ~a|~b, 0110 ~(a|b), 0111 ~(a^b).
  - 1000 vcpop, 1001 vfirst, 1010 vmsbf, 1011 vmsif, 1100 vmsof.
  - 1101–1111 reserved: out_vec = 0, out_valid still propagates.
- Cross-beat ops operate on x = a&b.
- Vector state: found flag, XLEN-bit popcount accumulator, beat index counter.
  - Cleared by reset.
  - Cleared on any valid beat with in_start, before that beat is evaluated.
  - Updated only on valid beats; bubbles leave it unchanged.
- vcpop: acc += popcount(x). out_vec = 0. On the in_end beat, out_scalar = final acc.
- vfirst: on the first set bit p, latch index*REQ_DATA_WIDTH + p and set found. Later set bits are ignored. On the in_end beat, out_scalar = latched value, or all-ones (-1) if never found. out_vec = 0.
- If found is already set, vmsbf/vmsif/vmsof output 0 for the beat. Otherwise, with p = the first set bit of x in the beat:
  - vmsbf: bits below p = 1.
  - vmsif: bits up to and including p = 1.
  - vmsof: only bit p = 1.
  - If x = 0 in the beat: vmsbf/vmsif output all-ones, vmsof outputs 0.
- The caller merges inactive elements; this block does not.
- The beat index increments on every valid beat and wraps modulo 2^(XLEN-log2(REQ_DATA_WIDTH)).
- Invalid beats are zeroed at the input register, so out_vec, out_addr and out_scalar are 0 whenever their valid is low.
- A valid beat with in_start and in_end both set is a complete one-beat vector.
- in_start mid-vector aborts the previous vector; it produces no scalar result.
- in_end without a prior in_start after reset uses the reset state.
- Logical opcodes ignore and do not disturb the vector state.

## Timing
- The input register is stage 0. Operation evaluation and vector-state update occur in stage 1.
- Stage 1 is followed by LATENCY-2 delay stages; out_valid asserts exactly LATENCY cycles after in_valid.
- Full throughput: one beat per cycle, with dependent beats back-to-back. A new vector may start on the cycle after in_end.
- out_scalar and out_scalar_valid are aligned with the out_valid of the in_end beat.
- Reset: all outputs and all pipeline and state registers go to 0 asynchronously. The first valid beat after reset deassertion is accepted normally.
- Reset mid-vector discards all in-flight beats; no output for them ever appears.

## Structure
- Package vmask_pkg holds:
  - opcode localparams (VM_AND … VM_XNOR, VM_CPOP, VM_FIRST, VM_SBF, VM_SIF, VM_SOF);
  - the LATENCY minimum;
  - a function for the popcount width.
- Sub-module vmask_first_finder, combinational: takes the beat x and returns any-set, the first index p, and the sbf/sif/sof beat masks. It is instantiated once in stage 1.
- The delay stages are a generate-loop shift register of {valid, scalar_valid, addr, vec, scalar}.

## Test plan
- Logical, opcode 0000: m0 = 0xF0F0F0F0F0F0F0F0, m1 = 0xFF00FF00FF00FF00, addr 0x40 → 6 cycles later out_vec = 0xF000F000F000F000, out_addr = 0x40, out_scalar_valid = 0.
- vcpop over 3 consecutive beats, m1 all-ones, m0 = all-ones, 0x1, 0x0 → out_scalar = 65 with the third out_valid; out_vec = 0 on all three.
- vfirst, 2 beats: m0 = 0 then 0x100 → out_scalar = 72. Repeat with all-zero beats → out_scalar = 0xFFFFFFFF.
- Beats 0 then 0x10:
  - vmsbf → out_vec = all-ones, then 0xF.
  - vmsif → all-ones, then 0x1F.
  - vmsof → 0, then 0x10.
  - Repeat with a bubble between the beats → identical results.
- Back-to-back vectors: a vcpop vector ending on cycle n, next vcpop starting on n+1 → second count independent of the first. A single beat with start+end, m0 = 0x3 → count 2.
- Assert rst during beat 2 of a 3-beat vcpop → all outputs 0 immediately; no stale out_valid. A fresh vector afterwards counts from 0.
